// File: rtl/comm_sequencer.sv
// comm_sequencer: triggers every enabled ultrasonic channel, collects the
// distances, sends them as a framed byte stream over a valid/ready TX link
// and waits for a one-byte reply. If no reply arrives in time, the stored
// frame is sent again, up to a fixed number of retries. A sticky error flag
// marks a transaction that ran out of retries.
module comm_sequencer #(
  parameter int NUM_SENSORS  = 2,
  parameter int DIST_W       = 16,
  parameter int MEAS_TIMEOUT = 1000000,
  parameter int RX_TIMEOUT   = 500000,
  parameter int MAX_RETRIES  = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_communication,
  input  logic [NUM_SENSORS-1:0]        sensor_mask,
  output logic [NUM_SENSORS-1:0]        start_ultra,
  input  logic [NUM_SENSORS-1:0]        ultrasonic_valid,
  input  logic [NUM_SENSORS*DIST_W-1:0] ultrasonic_distance,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic                          rx_ready,
  output logic [7:0]                    cmd_data,
  output logic                          data_valid,
  output logic                          error,
  output logic                          busy,
  output logic [2:0]                    output_state
);

  localparam int TOTAL_W    = NUM_SENSORS * DIST_W;
  localparam int DATA_BYTES = TOTAL_W / 8;
  localparam int FL         = 1 + DATA_BYTES;
  localparam int MAX_A      = (FL > MEAS_TIMEOUT) ? FL : MEAS_TIMEOUT;
  localparam int MAX_B      = (MAX_A > RX_TIMEOUT) ? MAX_A : RX_TIMEOUT;
  localparam int MAX_C      = (MAX_B > (MAX_RETRIES + 1)) ? MAX_B : (MAX_RETRIES + 1);
  // The extra bit keeps every counter clear of wrapping before its compare fires.
  localparam int CW         = $clog2(MAX_C) + 1;

  localparam logic [7:0]    HEADER       = 8'hA5;
  localparam logic [CW-1:0] LAST_BYTE    = CW'(FL - 1);
  localparam logic [CW-1:0] MEAS_LAST    = CW'(MEAS_TIMEOUT - 1);
  localparam logic [CW-1:0] RX_LAST      = CW'(RX_TIMEOUT - 1);
  localparam logic [CW-1:0] RETRY_LIMIT  = CW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MEASURE = 3'd1,
    S_SEND    = 3'd2,
    S_RECEIVE = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  state_t                 state_q;
  logic [NUM_SENSORS-1:0] mask_q;
  logic [NUM_SENSORS-1:0] captured_q;
  logic [TOTAL_W-1:0]     dist_q;
  logic [CW-1:0]          byteCnt_q;
  logic [CW-1:0]          tmo_q;
  logic [CW-1:0]          retry_q;

  logic [NUM_SENSORS-1:0] startUltra_q;
  logic [7:0]             txData_q;
  logic                   txValid_q;
  logic                   rxReady_q;
  logic [7:0]             cmdData_q;
  logic                   dataValid_q;
  logic                   error_q;

  logic [NUM_SENSORS-1:0] newCapture;
  logic [NUM_SENSORS-1:0] captured_d;
  logic [TOTAL_W-1:0]     dist_d;
  logic [TOTAL_W-1:0]     distTimeout_d;
  logic [7:0]             nextByte_d;
  logic                   measDone;
  logic                   measTimeout;
  logic                   rxTimeout;
  logic                   txFire;
  logic                   rxFire;
  logic                   lastByte;
  logic                   canRetry;

  // Capture bookkeeping: only the first strobe of each enabled channel is
  // kept, and on a measurement timeout the channels still missing read as
  // all-ones. A strobe in the timeout cycle still lands in dist_d first.
  always_comb begin
    newCapture    = ultrasonic_valid & mask_q & ~captured_q;
    captured_d    = captured_q | newCapture;
    dist_d        = dist_q;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (newCapture[i]) begin
        dist_d[i*DIST_W +: DIST_W] = ultrasonic_distance[i*DIST_W +: DIST_W];
      end
    end
    distTimeout_d = dist_d;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (mask_q[i] && !captured_d[i]) begin
        distTimeout_d[i*DIST_W +: DIST_W] = '1;
      end
    end
    measDone    = ((captured_d & mask_q) == mask_q);
    measTimeout = (tmo_q == MEAS_LAST);
  end

  // Next frame byte after the one on the link: frame byte n+1 is data byte n,
  // and the packed distance vector is already in little-endian channel order.
  always_comb begin
    nextByte_d = 8'h00;
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (byteCnt_q == CW'(b)) begin
        nextByte_d = dist_q[b*8 +: 8];
      end
    end
    txFire    = txValid_q && tx_ready;
    rxFire    = rxReady_q && rx_valid;
    lastByte  = (byteCnt_q == LAST_BYTE);
    rxTimeout = (tmo_q == RX_LAST);
    canRetry  = (retry_q < RETRY_LIMIT);
  end

  // Main sequencer. Every output is registered here, and the header byte is
  // loaded on the edge that enters SEND so it is valid in the first SEND cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      mask_q       <= '0;
      captured_q   <= '0;
      dist_q       <= '0;
      byteCnt_q    <= '0;
      tmo_q        <= '0;
      retry_q      <= '0;
      startUltra_q <= '0;
      txData_q     <= 8'h00;
      txValid_q    <= 1'b0;
      rxReady_q    <= 1'b0;
      cmdData_q    <= 8'h00;
      dataValid_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      startUltra_q <= '0;
      dataValid_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_communication) begin
            mask_q       <= sensor_mask;
            captured_q   <= '0;
            dist_q       <= '0;
            tmo_q        <= '0;
            retry_q      <= '0;
            error_q      <= 1'b0;
            startUltra_q <= sensor_mask;
            state_q      <= S_MEASURE;
          end
        end

        S_MEASURE: begin
          captured_q <= captured_d;
          if (measDone) begin
            dist_q    <= dist_d;
            byteCnt_q <= '0;
            txData_q  <= HEADER;
            txValid_q <= 1'b1;
            state_q   <= S_SEND;
          end else if (measTimeout) begin
            dist_q    <= distTimeout_d;
            byteCnt_q <= '0;
            txData_q  <= HEADER;
            txValid_q <= 1'b1;
            state_q   <= S_SEND;
          end else begin
            dist_q <= dist_d;
            tmo_q  <= tmo_q + 1'b1;
          end
        end

        S_SEND: begin
          if (txFire) begin
            if (lastByte) begin
              txValid_q <= 1'b0;
              rxReady_q <= 1'b1;
              tmo_q     <= '0;
              state_q   <= S_RECEIVE;
            end else begin
              byteCnt_q <= byteCnt_q + 1'b1;
              txData_q  <= nextByte_d;
            end
          end
        end

        S_RECEIVE: begin
          if (rxFire) begin
            cmdData_q   <= rx_data;
            dataValid_q <= 1'b1;
            rxReady_q   <= 1'b0;
            state_q     <= S_IDLE;
          end else if (rxTimeout) begin
            rxReady_q <= 1'b0;
            tmo_q     <= '0;
            if (canRetry) begin
              retry_q   <= retry_q + 1'b1;
              byteCnt_q <= '0;
              txData_q  <= HEADER;
              txValid_q <= 1'b1;
              state_q   <= S_SEND;
            end else begin
              state_q <= S_ERROR;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        S_ERROR: begin
          error_q <= 1'b1;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign start_ultra  = startUltra_q;
  assign tx_data      = txData_q;
  assign tx_valid     = txValid_q;
  assign rx_ready     = rxReady_q;
  assign cmd_data     = cmdData_q;
  assign data_valid   = dataValid_q;
  assign error        = error_q;
  assign busy         = (state_q != S_IDLE);
  assign output_state = state_q;

endmodule

// File: tb/tb_comm_sequencer.sv
// tb_comm_sequencer: directed vector table for comm_sequencer plus hand-written
// reset sequences. Inputs are driven and outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_comm_sequencer;

  localparam int NS = 2;
  localparam int DW = 16;

  typedef logic [4:0][7:0] frame_t;

  typedef struct {
    logic [1:0]  mask;
    logic [15:0] d0;
    logic [15:0] d1;
    int          delay0;
    int          delay1;
    bit          repeat0;
    bit          toggleReady;
    int          replyWindow;
    int          replyCycle;
    logic [7:0]  reply;
    frame_t      expFrame;
    int          expFrames;
    int          expMeasCycles;
    logic [7:0]  expCmd;
    bit          expError;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start_communication;
  logic [NS-1:0]    sensor_mask;
  logic [NS-1:0]    start_ultra;
  logic [NS-1:0]    ultrasonic_valid;
  logic [NS*DW-1:0] ultrasonic_distance;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [7:0]       cmd_data;
  logic             data_valid;
  logic             error;
  logic             busy;
  logic [2:0]       output_state;

  int         checks = 0;
  int         fails  = 0;
  logic [7:0] txLog[$];
  int         measCycles;
  int         ultraCycles;
  logic [1:0] firstUltra;
  int         pulses;
  int         errCycles;
  logic       finalError;
  logic [7:0] finalCmd;
  logic       finalBusy;
  logic [2:0] finalState;
  vec_t       vecs[8];
  vec_t       resetVec;

  comm_sequencer #(
    .NUM_SENSORS (NS),
    .DIST_W      (DW),
    .MEAS_TIMEOUT(50),
    .RX_TIMEOUT  (20),
    .MAX_RETRIES (2)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .start_communication(start_communication),
    .sensor_mask        (sensor_mask),
    .start_ultra        (start_ultra),
    .ultrasonic_valid   (ultrasonic_valid),
    .ultrasonic_distance(ultrasonic_distance),
    .tx_data            (tx_data),
    .tx_valid           (tx_valid),
    .tx_ready           (tx_ready),
    .rx_data            (rx_data),
    .rx_valid           (rx_valid),
    .rx_ready           (rx_ready),
    .cmd_data           (cmd_data),
    .data_valid         (data_valid),
    .error              (error),
    .busy               (busy),
    .output_state       (output_state)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  function automatic frame_t frame5(input logic [7:0] b0, input logic [7:0] b1,
                                    input logic [7:0] b2, input logic [7:0] b3,
                                    input logic [7:0] b4);
    frame5 = {b4, b3, b2, b1, b0};
  endfunction

  task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one full transaction, from start to the return to IDLE, recording
  // what the DUT did.
  task automatic applyStimulus(input int idx, input vec_t v);
    int         k;
    int         sendCyc;
    int         win;
    int         winCyc;
    int         cyc;
    logic [2:0] prevState;
    bit         prevStall;
    logic [7:0] prevData;
    bit         done;
    txLog.delete();
    measCycles  = 0;
    ultraCycles = 0;
    firstUltra  = 2'b00;
    pulses      = 0;
    errCycles   = 0;
    @(negedge clk);
    sensor_mask         = v.mask;
    ultrasonic_distance = {v.d1, v.d0};
    ultrasonic_valid    = '0;
    rx_valid            = 1'b0;
    tx_ready            = 1'b1;
    start_communication = 1'b1;
    @(negedge clk);
    start_communication = 1'b0;
    k = 0; sendCyc = 0; win = 0; winCyc = 0; cyc = 0;
    prevState = 3'd0; prevStall = 1'b0; prevData = 8'h00; done = 1'b0;
    while (!done) begin
      if (data_valid) pulses++;
      if (start_ultra != 2'b00) ultraCycles++;
      if (output_state == 3'd0) begin
        done = 1'b1;
      end else begin
        ultrasonic_valid = '0;
        rx_valid         = 1'b0;
        tx_ready         = 1'b1;
        case (output_state)
          3'd1: begin
            if (k == 0) firstUltra = start_ultra;
            ultrasonic_valid[0] = (k == v.delay0) || (v.repeat0 && v.delay0 >= 0 && k > v.delay0);
            ultrasonic_valid[1] = (k == v.delay1);
            ultrasonic_distance[15:0] = (v.delay0 >= 0 && k > v.delay0) ? ~v.d0 : v.d0;
            k++;
            measCycles++;
          end
          3'd2: begin
            tx_ready = v.toggleReady ? sendCyc[0] : 1'b1;
            sendCyc++;
            if (prevStall)
              expectEq($sformatf("v%0d stall hold {valid,data}", idx), {23'd0, tx_valid, tx_data},
                       {23'd0, 1'b1, prevData});
            if (tx_valid && tx_ready) txLog.push_back(tx_data);
            prevStall = tx_valid && !tx_ready;
            prevData  = tx_data;
          end
          3'd3: begin
            if (prevState != 3'd3) begin
              win++;
              winCyc = 0;
            end else begin
              winCyc++;
            end
            if (win == v.replyWindow && winCyc == v.replyCycle) begin
              rx_valid = 1'b1;
              rx_data  = v.reply;
            end
          end
          3'd4: errCycles++;
          default: ;
        endcase
        if (output_state != 3'd2) prevStall = 1'b0;
        if (output_state != 3'd3) begin
          rx_valid = 1'b1;
          rx_data  = 8'hEE;
        end
        prevState = output_state;
        cyc++;
        if (cyc > 1000) begin
          checks++;
          fails++;
          $display("[TB] FAIL v%0d cycle budget: got no return to IDLE, expected IDLE within 1000 cycles", idx);
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
    rx_valid         = 1'b0;
    ultrasonic_valid = '0;
    tx_ready         = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (data_valid) pulses++;
    end
    finalError = error;
    finalCmd   = cmd_data;
    finalBusy  = busy;
    finalState = output_state;
  endtask

  // Compares the recorded transaction against the vector's expectations.
  task automatic checkOutput(input int idx, input vec_t v);
    expectEq($sformatf("v%0d start_ultra pulse value", idx), 32'(firstUltra), 32'(v.mask));
    expectEq($sformatf("v%0d start_ultra cycles", idx), ultraCycles, (v.mask != 2'b00) ? 1 : 0);
    expectEq($sformatf("v%0d MEASURE cycles", idx), measCycles, v.expMeasCycles);
    expectEq($sformatf("v%0d bytes sent", idx), txLog.size(), v.expFrames * 5);
    foreach (txLog[i])
      expectEq($sformatf("v%0d byte %0d", idx, i), 32'(txLog[i]), 32'(v.expFrame[i % 5]));
    expectEq($sformatf("v%0d cmd_data", idx), 32'(finalCmd), 32'(v.expCmd));
    expectEq($sformatf("v%0d data_valid pulses", idx), pulses, (v.replyWindow > 0) ? 1 : 0);
    expectEq($sformatf("v%0d ERROR state cycles", idx), errCycles, v.expError ? 1 : 0);
    expectEq($sformatf("v%0d error held in IDLE", idx), 32'(finalError), 32'(v.expError));
    expectEq($sformatf("v%0d {busy,state} at end", idx), {28'd0, finalBusy, finalState}, 32'd0);
  endtask

  initial begin
    int sent;
    int cyc;

    vecs[0] = '{mask:2'b11, d0:16'h1234, d1:16'hABCD, delay0:5, delay1:5, repeat0:1'b0,
                toggleReady:1'b0, replyWindow:1, replyCycle:3, reply:8'h3C,
                expFrame:frame5(8'hA5, 8'h34, 8'h12, 8'hCD, 8'hAB), expFrames:1,
                expMeasCycles:6, expCmd:8'h3C, expError:1'b0};
    vecs[1] = '{mask:2'b11, d0:16'h1234, d1:16'hABCD, delay0:5, delay1:5, repeat0:1'b0,
                toggleReady:1'b1, replyWindow:1, replyCycle:3, reply:8'h77,
                expFrame:frame5(8'hA5, 8'h34, 8'h12, 8'hCD, 8'hAB), expFrames:1,
                expMeasCycles:6, expCmd:8'h77, expError:1'b0};
    vecs[2] = '{mask:2'b01, d0:16'h1111, d1:16'hBEEF, delay0:-1, delay1:3, repeat0:1'b0,
                toggleReady:1'b0, replyWindow:1, replyCycle:0, reply:8'h11,
                expFrame:frame5(8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h00), expFrames:1,
                expMeasCycles:50, expCmd:8'h11, expError:1'b0};
    vecs[3] = '{mask:2'b11, d0:16'h0102, d1:16'h0304, delay0:1, delay1:2, repeat0:1'b0,
                toggleReady:1'b0, replyWindow:3, replyCycle:5, reply:8'h55,
                expFrame:frame5(8'hA5, 8'h02, 8'h01, 8'h04, 8'h03), expFrames:3,
                expMeasCycles:3, expCmd:8'h55, expError:1'b0};
    vecs[4] = '{mask:2'b10, d0:16'hFFFF, d1:16'hC0DE, delay0:0, delay1:0, repeat0:1'b0,
                toggleReady:1'b1, replyWindow:0, replyCycle:0, reply:8'h00,
                expFrame:frame5(8'hA5, 8'h00, 8'h00, 8'hDE, 8'hC0), expFrames:3,
                expMeasCycles:1, expCmd:8'h55, expError:1'b1};
    vecs[5] = '{mask:2'b00, d0:16'h7777, d1:16'h8888, delay0:-1, delay1:-1, repeat0:1'b0,
                toggleReady:1'b0, replyWindow:1, replyCycle:2, reply:8'h9A,
                expFrame:frame5(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00), expFrames:1,
                expMeasCycles:1, expCmd:8'h9A, expError:1'b0};
    vecs[6] = '{mask:2'b11, d0:16'h5AC3, d1:16'h0F1E, delay0:1, delay1:4, repeat0:1'b1,
                toggleReady:1'b0, replyWindow:2, replyCycle:3, reply:8'h6B,
                expFrame:frame5(8'hA5, 8'hC3, 8'h5A, 8'h1E, 8'h0F), expFrames:2,
                expMeasCycles:5, expCmd:8'h6B, expError:1'b0};
    vecs[7] = '{mask:2'b11, d0:16'h1357, d1:16'h2468, delay0:2, delay1:49, repeat0:1'b0,
                toggleReady:1'b0, replyWindow:1, replyCycle:19, reply:8'hE1,
                expFrame:frame5(8'hA5, 8'h57, 8'h13, 8'h68, 8'h24), expFrames:1,
                expMeasCycles:50, expCmd:8'hE1, expError:1'b0};
    resetVec = vecs[0];

    reset               = 1'b0;
    start_communication = 1'b0;
    sensor_mask         = '0;
    ultrasonic_valid    = '0;
    ultrasonic_distance = '0;
    tx_ready            = 1'b1;
    rx_data             = 8'h00;
    rx_valid            = 1'b0;

    // Reset state, with a start request held during reset.
    @(negedge clk);
    start_communication = 1'b1;
    sensor_mask         = 2'b11;
    @(negedge clk);
    expectEq("reset {busy,state}", {28'd0, busy, output_state}, 32'd0);
    expectEq("reset {tx_valid,rx_ready,data_valid,error}",
             {28'd0, tx_valid, rx_ready, data_valid, error}, 32'd0);
    expectEq("reset {start_ultra,tx_data,cmd_data}", {14'd0, start_ultra, tx_data, cmd_data}, 32'd0);
    start_communication = 1'b0;
    reset               = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(i, vecs[i]);
      checkOutput(i, vecs[i]);
    end

    // Reset asserted while the third byte is on the link.
    @(negedge clk);
    sensor_mask         = 2'b11;
    ultrasonic_distance = {16'hABCD, 16'h1234};
    ultrasonic_valid    = '0;
    rx_valid            = 1'b0;
    tx_ready            = 1'b1;
    start_communication = 1'b1;
    @(negedge clk);
    start_communication = 1'b0;
    ultrasonic_valid    = 2'b11;
    @(negedge clk);
    ultrasonic_valid    = '0;
    sent = 0;
    cyc  = 0;
    while (sent < 2 && cyc < 20) begin
      if (tx_valid && tx_ready) sent++;
      @(negedge clk);
      cyc++;
    end
    expectEq("midsend bytes before reset", sent, 2);
    expectEq("midsend {state,tx_data} before reset", {21'd0, output_state, tx_data}, {21'd0, 3'd2, 8'h12});
    #2 reset = 1'b0;
    #1;
    expectEq("midsend {tx_valid,busy} after reset", {30'd0, tx_valid, busy}, 32'd0);
    expectEq("midsend output_state after reset", 32'(output_state), 32'd0);
    expectEq("midsend {tx_data,cmd_data} after reset", {16'd0, tx_data, cmd_data}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(8, resetVec);
    checkOutput(8, resetVec);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
